data_mem_arbiter: RTL

- Shares the single-port data RAM (256 x 32, combinational read, synchronous write) between two requesters: the pipeline MEM stage (CPU) and the debug/DMA unit (DBG).
- CPU has default priority.
- DBG is served after a bounded wait, enforced by a starvation counter; the CPU is stalled for the cycle DBG owns the port.
- Sits between the MEM-stage pipeline register and the RAM; cpu_stall feeds the pipeline stall/freeze logic.

---
 rtl/data_mem_arb_pkg.sv | 13 +
 rtl/arb_starve_counter.sv | 33 +++
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// The RAM behind the arbiter is 256 x 32, so the default widths are 8 and 32.
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    CPU_PRI  = 1'b0,
    DBG_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating starvation counter for the debug requester.
// When the count reaches LIMIT, expired rises and the requester wins the port.
module arb_starve_counter
  import data_mem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != LIM)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // LIMIT of 0 makes expired constant high: debug wins whenever it is eligible.
  assign expired = (cnt_reg >= LIM);

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter: CPU MEM stage has priority, debug/DMA gets a bounded wait.
// Define ARB_PERF_CNT_EN to build the stall/grant performance counters.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_spo,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_gnt_cnt
);

  arb_state_e state_reg, state_next;
  logic       cpu_req;
  logic       dbg_win;
  logic       starve_expired;
  logic       starve_clr;
  logic       starve_inc;

  assign cpu_req = cpu_re | cpu_we;
  assign dbg_win = (state_reg == CPU_PRI) & dbg_req & (~cpu_req | starve_expired);

  // Counter only moves while debug is eligible; it freezes in the response cycle.
  assign starve_clr = (state_reg == CPU_PRI) & (dbg_win | ~dbg_req);
  assign starve_inc = (state_reg == CPU_PRI) & dbg_req & ~dbg_win;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .clr     (starve_clr),
    .inc     (starve_inc),
    .expired (starve_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CPU_PRI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dbg_gnt    = 1'b0;
    cpu_stall  = 1'b0;
    ram_a      = cpu_addr;
    ram_d      = cpu_wdata;
    ram_we     = cpu_we;
    case (state_reg)
      CPU_PRI: begin
        if (dbg_win) begin
          state_next = DBG_RESP;
        end
      end
      DBG_RESP: begin
        state_next = CPU_PRI;
      end
      default: begin
        state_next = CPU_PRI;
      end
    endcase
    if (dbg_win) begin
      dbg_gnt   = 1'b1;
      cpu_stall = cpu_req;
      ram_a     = dbg_addr;
      ram_d     = dbg_wdata;
      ram_we    = dbg_we;
    end
  end

  assign cpu_rdata = ram_spo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_win & ~dbg_we;
      if (dbg_win && !dbg_we) begin
        dbg_rdata <= ram_spo;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_gnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_gnt_reg   <= '0;
    end else begin
      if (cpu_stall) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (dbg_gnt) begin
        perf_gnt_reg <= perf_gnt_reg + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_reg;
  assign perf_gnt_cnt   = perf_gnt_reg;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_gnt_cnt   = 32'd0;
`endif

endmodule
